// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID-stage decode and ID->EX->MEM->WB control pipeline with load-use stall, flush and syscall halt
module ctrl_pipe #(
    parameter int REG_AW          = 5,
    parameter int ALUOP_W         = 4,
    parameter int HALT_ON_SYSCALL = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic [REG_AW-1:0]  rs,
    input  logic [REG_AW-1:0]  rt,
    input  logic [REG_AW-1:0]  rd,
    input  logic               ex_taken,
    input  logic               resume,
    output logic               stall,
    output logic               illegal,
    output logic               halted,
    output logic               ex_valid,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_alu_src,
    output logic               ex_zero_ext,
    output logic               ex_shamt,
    output logic               ex_branch,
    output logic               ex_bne,
    output logic               ex_jump,
    output logic               ex_jr,
    output logic               ex_jal,
    output logic               mem_valid,
    output logic               mem_read,
    output logic               mem_write,
    output logic               wb_valid,
    output logic               wb_reg_write,
    output logic               wb_mem_to_reg,
    output logic [REG_AW-1:0]  wb_dst
);
    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
        logic               zero_ext;
        logic               shamt;
        logic               branch;
        logic               bne;
        logic               jump;
        logic               jr;
        logic               jal;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               reg_write;
        logic [REG_AW-1:0]  dst;
    } ctrl_t;
    state_t            r_state;
    logic [1:0]        r_cnt;
    logic              r_halted;
    ctrl_t             w_dec;
    ctrl_t             r_ex;
    logic              r_ex_valid;
    logic              r_mem_valid;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_mem_to_reg;
    logic              r_mem_reg_write;
    logic [REG_AW-1:0] r_mem_dst;
    logic              r_wb_valid;
    logic              r_wb_reg_write;
    logic              r_wb_mem_to_reg;
    logic [REG_AW-1:0] r_wb_dst;
    logic              w_legal;
    logic              w_syscall;
    logic              w_reads_rs;
    logic              w_reads_rt;
    logic              w_wr;
    logic              w_hold;
    logic              w_hazard;
    logic              w_issue;
    // Decode the ID instruction into its EX/MEM/WB control bundle
    always_comb begin
        w_dec      = '0;
        w_legal    = 1'b1;
        w_syscall  = 1'b0;
        w_reads_rs = 1'b0;
        w_reads_rt = 1'b0;
        w_wr       = 1'b0;
        w_dec.dst  = (op == 6'h00) ? rd : rt;
        if (op == 6'h00) begin
            case (funct)
                6'h20: {w_wr, w_reads_rs, w_reads_rt} = 3'b111;
                6'h22: begin {w_wr, w_reads_rs, w_reads_rt} = 3'b111; w_dec.alu_op = ALUOP_W'(1); end
                6'h24: begin {w_wr, w_reads_rs, w_reads_rt} = 3'b111; w_dec.alu_op = ALUOP_W'(2); end
                6'h25: begin {w_wr, w_reads_rs, w_reads_rt} = 3'b111; w_dec.alu_op = ALUOP_W'(3); end
                6'h2A: begin {w_wr, w_reads_rs, w_reads_rt} = 3'b111; w_dec.alu_op = ALUOP_W'(4); end
                6'h00: begin w_wr = 1'b1; w_reads_rt = 1'b1; w_dec.shamt = 1'b1; w_dec.alu_op = ALUOP_W'(5); end
                6'h08: begin w_reads_rs = 1'b1; w_dec.jr = 1'b1; end
                6'h0C: w_syscall = 1'b1;
                default: w_legal = 1'b0;
            endcase
        end else begin
            case (op)
                6'h08: begin w_wr = 1'b1; w_reads_rs = 1'b1; w_dec.alu_src = 1'b1; end
                6'h0C: begin w_wr = 1'b1; w_reads_rs = 1'b1; w_dec.alu_src = 1'b1; w_dec.zero_ext = 1'b1; w_dec.alu_op = ALUOP_W'(2); end
                6'h0D: begin w_wr = 1'b1; w_reads_rs = 1'b1; w_dec.alu_src = 1'b1; w_dec.zero_ext = 1'b1; w_dec.alu_op = ALUOP_W'(3); end
                6'h23: begin w_wr = 1'b1; w_reads_rs = 1'b1; w_dec.alu_src = 1'b1; w_dec.mem_read = 1'b1; w_dec.mem_to_reg = 1'b1; end
                6'h2B: begin w_reads_rs = 1'b1; w_reads_rt = 1'b1; w_dec.alu_src = 1'b1; w_dec.mem_write = 1'b1; end
                6'h04: begin w_reads_rs = 1'b1; w_reads_rt = 1'b1; w_dec.branch = 1'b1; w_dec.alu_op = ALUOP_W'(1); end
                6'h05: begin w_reads_rs = 1'b1; w_reads_rt = 1'b1; w_dec.branch = 1'b1; w_dec.bne = 1'b1; w_dec.alu_op = ALUOP_W'(1); end
                6'h02: w_dec.jump = 1'b1;
                6'h03: begin w_wr = 1'b1; w_dec.jump = 1'b1; w_dec.jal = 1'b1; w_dec.dst = REG_AW'(31); end
                default: w_legal = 1'b0;
            endcase
        end
        w_dec.reg_write = w_wr && (w_dec.dst != '0);
    end
    assign w_hold   = r_state != RUN;
    assign w_hazard = id_valid && r_ex_valid && r_ex.mem_read && (r_ex.dst != '0) &&
                      ((r_ex.dst == rs && w_reads_rs) || (r_ex.dst == rt && w_reads_rt));
    assign w_issue  = id_valid && !ex_taken && !w_hold && !w_hazard && w_legal;
    assign stall    = w_hold || (w_hazard && !ex_taken);
    assign illegal  = rst_n && id_valid && !w_legal && !ex_taken && !w_hold;
    assign halted   = r_halted;
    // RUN/DRAIN/HALT sequencing around a syscall, with the drain counter covering EX->MEM->WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_cnt    <= 2'd0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                RUN: if (w_issue && w_syscall && HALT_ON_SYSCALL != 0) begin
                    r_state <= DRAIN;
                    r_cnt   <= 2'd2;
                end
                DRAIN: if (r_cnt == 2'd0) begin
                    r_state  <= HALT;
                    r_halted <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 2'd1;
                end
                HALT: if (resume) begin
                    r_state  <= RUN;
                    r_halted <= 1'b0;
                end
                default: r_state <= RUN;
            endcase
        end
    end
    // EX takes the decoded bundle on issue, otherwise a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
            r_ex       <= '0;
        end else begin
            r_ex_valid <= w_issue;
            r_ex       <= w_issue ? w_dec : '0;
        end
    end
    // MEM and WB advance unconditionally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_valid     <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_mem_reg_write <= 1'b0;
            r_mem_dst       <= '0;
            r_wb_valid      <= 1'b0;
            r_wb_reg_write  <= 1'b0;
            r_wb_mem_to_reg <= 1'b0;
            r_wb_dst        <= '0;
        end else begin
            r_mem_valid     <= r_ex_valid;
            r_mem_read      <= r_ex.mem_read;
            r_mem_write     <= r_ex.mem_write;
            r_mem_to_reg    <= r_ex.mem_to_reg;
            r_mem_reg_write <= r_ex.reg_write;
            r_mem_dst       <= r_ex.dst;
            r_wb_valid      <= r_mem_valid;
            r_wb_reg_write  <= r_mem_reg_write;
            r_wb_mem_to_reg <= r_mem_to_reg;
            r_wb_dst        <= r_mem_dst;
        end
    end
    assign ex_valid      = r_ex_valid;
    assign ex_alu_op     = r_ex.alu_op;
    assign ex_alu_src    = r_ex.alu_src;
    assign ex_zero_ext   = r_ex.zero_ext;
    assign ex_shamt      = r_ex.shamt;
    assign ex_branch     = r_ex.branch;
    assign ex_bne        = r_ex.bne;
    assign ex_jump       = r_ex.jump;
    assign ex_jr         = r_ex.jr;
    assign ex_jal        = r_ex.jal;
    assign mem_valid     = r_mem_valid;
    assign mem_read      = r_mem_read;
    assign mem_write     = r_mem_write;
    assign wb_valid      = r_wb_valid;
    assign wb_reg_write  = r_wb_reg_write;
    assign wb_mem_to_reg = r_wb_mem_to_reg;
    assign wb_dst        = r_wb_dst;
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed-vector bench for ctrl_pipe with hand-computed expectations
module tb_ctrl_pipe;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       ex_taken;
    logic       resume;
    logic       stall;
    logic       illegal;
    logic       halted;
    logic       ex_valid;
    logic [3:0] ex_alu_op;
    logic       ex_alu_src;
    logic       ex_zero_ext;
    logic       ex_shamt;
    logic       ex_branch;
    logic       ex_bne;
    logic       ex_jump;
    logic       ex_jr;
    logic       ex_jal;
    logic       mem_valid;
    logic       mem_read;
    logic       mem_write;
    logic       wb_valid;
    logic       wb_reg_write;
    logic       wb_mem_to_reg;
    logic [4:0] wb_dst;
    int         n_chk = 0;
    int         n_err = 0;
    ctrl_pipe dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .op(op), .funct(funct),
        .rs(rs), .rt(rt), .rd(rd), .ex_taken(ex_taken), .resume(resume),
        .stall(stall), .illegal(illegal), .halted(halted),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_zero_ext(ex_zero_ext), .ex_shamt(ex_shamt), .ex_branch(ex_branch),
        .ex_bne(ex_bne), .ex_jump(ex_jump), .ex_jr(ex_jr), .ex_jal(ex_jal),
        .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #2;
    endtask
    task automatic ins(input logic [5:0] o, input logic [5:0] f, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        id_valid = 1'b1;
        op = o;
        funct = f;
        rs = s;
        rt = t;
        rd = d;
    endtask
    task automatic idle;
        id_valid = 1'b0;
        ex_taken = 1'b0;
        resume = 1'b0;
        repeat (3) tick();
    endtask
    initial begin
        rst_n = 1'b0; id_valid = 1'b0; op = '0; funct = '0; rs = '0; rt = '0; rd = '0;
        ex_taken = 1'b0; resume = 1'b0;
        #3;
        chk("rst_stall", stall, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_halted", halted, 0);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        #10 rst_n = 1'b1;
        tick();
        // load-use: lw r8 ; add r9,r8,r8
        ins(6'h23, 6'h00, 5'd0, 5'd8, 5'd0);
        #1 chk("lw_nostall", stall, 0);
        tick();
        ins(6'h00, 6'h20, 5'd8, 5'd8, 5'd9);
        #1 chk("lu_stall", stall, 1);
        chk("lu_ex_lw", ex_valid, 1);
        tick();
        #1 chk("lu_bubble", ex_valid, 0);
        chk("lu_stall_once", stall, 0);
        chk("lu_mem_read", mem_read, 1);
        tick();
        id_valid = 1'b0;
        #1 chk("lu_add_ex", ex_valid, 1);
        chk("lw_wb_dst", wb_dst, 8);
        chk("lw_wb_m2r", wb_mem_to_reg, 1);
        chk("lw_wb_rw", wb_reg_write, 1);
        tick();
        tick();
        #1 chk("add_wb_valid", wb_valid, 1);
        chk("add_wb_dst", wb_dst, 9);
        chk("add_wb_m2r", wb_mem_to_reg, 0);
        idle();
        // hazard corner cases
        ins(6'h23, 6'h00, 5'd0, 5'd0, 5'd0);
        tick();
        ins(6'h00, 6'h20, 5'd0, 5'd0, 5'd9);
        #1 chk("lu_r0_none", stall, 0);
        tick();
        ins(6'h23, 6'h00, 5'd1, 5'd7, 5'd0);
        tick();
        ins(6'h02, 6'h00, 5'd7, 5'd7, 5'd0);
        #1 chk("lu_j_noread", stall, 0);
        tick();
        ins(6'h23, 6'h00, 5'd1, 5'd5, 5'd0);
        tick();
        ins(6'h2B, 6'h00, 5'd1, 5'd5, 5'd0);
        #1 chk("lu_sw_rt", stall, 1);
        tick();
        tick();
        id_valid = 1'b0;
        tick();
        #1 chk("sw_mem_write", mem_write, 1);
        idle();
        // decode stream: jal, sll, andi, bne
        ins(6'h03, 6'h00, 5'd0, 5'd0, 5'd0);
        tick();
        ins(6'h00, 6'h00, 5'd0, 5'd2, 5'd4);
        #1 chk("jal_jump", ex_jump, 1);
        chk("jal_jal", ex_jal, 1);
        tick();
        ins(6'h0C, 6'h00, 5'd1, 5'd6, 5'd0);
        #1 chk("sll_shamt", ex_shamt, 1);
        chk("sll_alu", ex_alu_op, 5);
        tick();
        ins(6'h05, 6'h00, 5'd1, 5'd2, 5'd0);
        #1 chk("andi_zext", ex_zero_ext, 1);
        chk("andi_alu", ex_alu_op, 2);
        chk("jal_wb_dst", wb_dst, 31);
        chk("jal_wb_rw", wb_reg_write, 1);
        tick();
        id_valid = 1'b0;
        #1 chk("bne_bne", ex_bne, 1);
        chk("bne_branch", ex_branch, 1);
        chk("bne_alu", ex_alu_op, 1);
        idle();
        // branch flush: beq in EX taken while ori r3 sits in ID
        ins(6'h04, 6'h00, 5'd1, 5'd2, 5'd0);
        tick();
        ins(6'h0D, 6'h00, 5'd1, 5'd3, 5'd0);
        ex_taken = 1'b1;
        #1 chk("beq_branch", ex_branch, 1);
        chk("flush_stall", stall, 0);
        chk("flush_illegal", illegal, 0);
        tick();
        ex_taken = 1'b0;
        id_valid = 1'b0;
        #1 chk("flush_bubble", ex_valid, 0);
        tick();
        tick();
        #1 chk("flush_wb_valid", wb_valid, 0);
        chk("flush_wb_rw", wb_reg_write, 0);
        idle();
        // illegal encodings and writes to r0
        ins(6'h00, 6'h01, 5'd0, 5'd0, 5'd0);
        #1 chk("ill_funct", illegal, 1);
        tick();
        ins(6'h3F, 6'h00, 5'd0, 5'd0, 5'd0);
        #1 chk("ill_op", illegal, 1);
        chk("ill_stall", stall, 0);
        tick();
        ins(6'h08, 6'h00, 5'd1, 5'd0, 5'd0);
        #1 chk("ill_pulse_end", illegal, 0);
        chk("ill_bubble", ex_valid, 0);
        tick();
        id_valid = 1'b0;
        #1 chk("addi_src", ex_alu_src, 1);
        chk("addi_ex_valid", ex_valid, 1);
        tick();
        tick();
        #1 chk("addi_r0_wb_valid", wb_valid, 1);
        chk("addi_r0_rw", wb_reg_write, 0);
        idle();
        // syscall drain and halt, resume ignored in DRAIN
        ins(6'h00, 6'h0C, 5'd0, 5'd0, 5'd0);
        #1 chk("sys_stall0", stall, 0);
        tick();
        ins(6'h00, 6'h20, 5'd2, 5'd3, 5'd1);
        #1 chk("sys_stall1", stall, 1);
        chk("sys_ex_valid", ex_valid, 1);
        chk("sys_ex_jr", ex_jr, 0);
        chk("sys_halted1", halted, 0);
        tick();
        resume = 1'b1;
        #1 chk("sys_stall2", stall, 1);
        chk("sys_drain_bubble", ex_valid, 0);
        tick();
        resume = 1'b0;
        #1 chk("sys_stall3", stall, 1);
        chk("sys_wb", wb_valid, 1);
        chk("sys_halted3", halted, 0);
        tick();
        #1 chk("sys_halted", halted, 1);
        chk("halt_stall", stall, 1);
        chk("halt_mem_bubble", mem_valid, 0);
        chk("halt_wb_bubble", wb_valid, 0);
        tick();
        #1 chk("halt_hold", halted, 1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        #1 chk("resume_halted", halted, 0);
        chk("resume_stall", stall, 0);
        tick();
        id_valid = 1'b0;
        #1 chk("resume_issue", ex_valid, 1);
        idle();
        // flush beats load-use and syscall
        ins(6'h23, 6'h00, 5'd0, 5'd8, 5'd0);
        tick();
        ins(6'h00, 6'h20, 5'd8, 5'd8, 5'd9);
        ex_taken = 1'b1;
        #1 chk("sim_lu_stall", stall, 0);
        tick();
        ins(6'h00, 6'h0C, 5'd0, 5'd0, 5'd0);
        #1 chk("sim_sys_stall", stall, 0);
        chk("sim_bubble", ex_valid, 0);
        tick();
        ex_taken = 1'b0;
        id_valid = 1'b0;
        #1 chk("sim_sys_bubble", ex_valid, 0);
        chk("sim_after_stall", stall, 0);
        tick();
        #1 chk("sim_run_stall", stall, 0);
        chk("sim_run_halted", halted, 0);
        idle();
        // reset while halted
        ins(6'h00, 6'h0C, 5'd0, 5'd0, 5'd0);
        tick();
        id_valid = 1'b0;
        repeat (3) tick();
        #1 chk("rh_halted", halted, 1);
        ins(6'h3F, 6'h00, 5'd0, 5'd0, 5'd0);
        rst_n = 1'b0;
        #1 chk("rh_halted0", halted, 0);
        chk("rh_stall0", stall, 0);
        chk("rh_illegal0", illegal, 0);
        chk("rh_ex0", ex_valid, 0);
        chk("rh_wb0", wb_valid, 0);
        #2 rst_n = 1'b1;
        ins(6'h00, 6'h20, 5'd2, 5'd3, 5'd1);
        #1 chk("rh_no_stall", stall, 0);
        tick();
        id_valid = 1'b0;
        #1 chk("rh_first_edge", ex_valid, 1);
        tick();
        tick();
        #1 chk("rh_wb_valid", wb_valid, 1);
        chk("rh_wb_dst", wb_dst, 1);
        chk("rh_wb_rw", wb_reg_write, 1);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
